// File: rtl/countdown_time_setter_if.sv
// Start/abort handshake between the time setter (initiator) and the countdown controller.
interface countdown_time_setter_if;
  logic start;
  logic end_timer;
  logic counting;
  logic done;

  modport master (
    output start,
    output end_timer,
    input  counting,
    input  done
  );

  modport slave (
    input  start,
    input  end_timer,
    output counting,
    output done
  );
endinterface

// File: rtl/countdown_time_setter.sv
// User-input front end for the countdown controller: debounces four buttons, edits the
// preset and issues one-cycle start/end_timer pulses.
// Optional macro AUTO_REPEAT_EN: held inc/dec auto-repeats in EDIT (0.5 s first, then 0.1 s).
module countdown_time_setter #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned MIN_TIME        = 1,
  parameter int unsigned MAX_TIME        = 15,
  parameter int unsigned DEFAULT_TIME    = 10,
  parameter int unsigned ACK_TIMEOUT     = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           btn_inc_i,
  input  logic                           btn_dec_i,
  input  logic                           btn_confirm_i,
  input  logic                           btn_clear_i,
  countdown_time_setter_if.master        ctl_if,
  output logic [7:0]                     countdown_time_o,
  output logic                           edit_mode_o,
  output logic                           finished_o
);

  localparam int unsigned DbW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned AckW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [DbW-1:0]  DbMax  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AckW-1:0] AckMax = AckW'(ACK_TIMEOUT - 1);
  localparam logic [7:0]      MinT   = 8'(MIN_TIME);
  localparam logic [7:0]      MaxT   = 8'(MAX_TIME);
  localparam logic [7:0]      DefT   = 8'(DEFAULT_TIME);

  // Button bit order: 0 inc, 1 dec, 2 confirm, 3 clear.
  localparam int unsigned BInc = 0;
  localparam int unsigned BDec = 1;
  localparam int unsigned BCnf = 2;
  localparam int unsigned BClr = 3;

  typedef enum logic [1:0] {StEdit, StWaitAck, StRun, StFinish} state_e;

  logic [3:0]     raw;
  logic [3:0]     sync1_q, sync2_q, db_q, db_prev_q;
  logic [DbW-1:0] db_cnt_q [4];
  logic [3:0]     press;

  state_e          state_q, state_d;
  logic [7:0]      preset_q, preset_d;
  logic [AckW-1:0] ack_cnt_q, ack_cnt_d;
  logic            start_q, start_d;
  logic            end_q, end_d;
  logic            finished_q, finished_d;

  assign raw = {btn_clear_i, btn_confirm_i, btn_dec_i, btn_inc_i};

  // Synchronise raw buttons, then accept a level only after it has been stable long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbMax) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RepW = 26;
  localparam logic [RepW-1:0] RepFirst = RepW'(50_000_000 - 1);
  localparam logic [RepW-1:0] RepNext  = RepW'(10_000_000 - 1);

  logic [RepW-1:0] rep_cnt_q;
  logic            rep_armed_q;
  logic            rep_hold;
  logic            rep_pulse;
  logic [RepW-1:0] rep_limit;

  // Exactly one of inc/dec held in EDIT keeps the repeat timer running.
  assign rep_hold  = (state_q == StEdit) && (db_q[BInc] ^ db_q[BDec]);
  assign rep_limit = rep_armed_q ? RepNext : RepFirst;
  assign rep_pulse = rep_hold && (rep_cnt_q == rep_limit);

  // Repeat timer: long first interval, shorter ones after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else if (!rep_hold) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else if (rep_pulse) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b1;
    end else begin
      rep_cnt_q <= rep_cnt_q + 1'b1;
    end
  end

  assign press = (db_q & ~db_prev_q) | {2'b00, {2{rep_pulse}} & db_q[1:0]};
`else
  assign press = db_q & ~db_prev_q;
`endif

  // Next-state and output decode; clear beats confirm beats inc/dec.
  always_comb begin
    state_d    = state_q;
    preset_d   = preset_q;
    ack_cnt_d  = ack_cnt_q;
    start_d    = 1'b0;
    end_d      = 1'b0;
    finished_d = finished_q;
    unique case (state_q)
      StEdit: begin
        ack_cnt_d = '0;
        if (press[BClr]) begin
          preset_d = DefT;
        end else if (press[BCnf]) begin
          start_d = 1'b1;
          state_d = StWaitAck;
        end else if (press[BInc] && !press[BDec]) begin
          if (preset_q < MaxT) preset_d = preset_q + 8'd1;
        end else if (press[BDec] && !press[BInc]) begin
          if (preset_q > MinT) preset_d = preset_q - 8'd1;
        end
      end
      StWaitAck: begin
        if (ctl_if.counting) begin
          state_d = StRun;
        end else if (ack_cnt_q == AckMax) begin
          state_d = StEdit;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      StRun: begin
        // done arrives with counting falling, so it must be tested first.
        if (ctl_if.done) begin
          finished_d = 1'b1;
          state_d    = StFinish;
        end else if (!ctl_if.counting) begin
          state_d = StEdit;
        end else if (press[BCnf]) begin
          end_d = 1'b1;
        end
      end
      StFinish: begin
        if (|press) begin
          finished_d = 1'b0;
          state_d    = StEdit;
        end
      end
      default: state_d = StEdit;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEdit;
      preset_q   <= DefT;
      ack_cnt_q  <= '0;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      preset_q   <= preset_d;
      ack_cnt_q  <= ack_cnt_d;
      start_q    <= start_d;
      end_q      <= end_d;
      finished_q <= finished_d;
    end
  end

  assign ctl_if.start     = start_q;
  assign ctl_if.end_timer = end_q;
  assign countdown_time_o = preset_q;
  assign edit_mode_o      = (state_q == StEdit);
  assign finished_o       = finished_q;

endmodule

// File: tb/tb_countdown_time_setter.sv
// Bench for countdown_time_setter with a fast debounce and a simple controller stand-in.
module tb_countdown_time_setter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic       btn_confirm = 1'b0;
  logic       btn_clear = 1'b0;
  logic [7:0] countdown_time;
  logic       edit_mode;
  logic       finished;

  countdown_time_setter_if ifc ();

  countdown_time_setter #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .btn_inc_i       (btn_inc),
    .btn_dec_i       (btn_dec),
    .btn_confirm_i   (btn_confirm),
    .btn_clear_i     (btn_clear),
    .ctl_if          (ifc),
    .countdown_time_o(countdown_time),
    .edit_mode_o     (edit_mode),
    .finished_o      (finished)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Controller stand-in: acknowledge start when enabled, drop counting on request.
  bit ack_en = 1'b0;
  bit drop_done = 1'b0;
  int drop_cnt = 0;
  int drop_seen = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      ifc.counting = 1'b0;
      ifc.done     = 1'b0;
    end else begin
      ifc.done = 1'b0;
      if (ifc.start && ack_en) begin
        ifc.counting = 1'b1;
      end else if (drop_cnt != drop_seen) begin
        ifc.counting = 1'b0;
        ifc.done     = drop_done;
        drop_seen    = drop_cnt;
      end
    end
  end

  // Pulse bookkeeping for start/end_timer and edit_mode rise timing.
  int start_total = 0, start_run = 0, start_max = 0, start_cyc = 0;
  int end_total = 0, end_run = 0, end_max = 0;
  int both_seen = 0, edit_rise_cyc = 0;
  bit prev_edit = 1'b0;

  always @(negedge clk) begin
    if (ifc.start === 1'b1) begin
      start_total++;
      start_run++;
      start_cyc = cyc;
      if (start_run > start_max) start_max = start_run;
    end else begin
      start_run = 0;
    end
    if (ifc.end_timer === 1'b1) begin
      end_total++;
      end_run++;
      if (end_run > end_max) end_max = end_run;
    end else begin
      end_run = 0;
    end
    if (ifc.start === 1'b1 && ifc.end_timer === 1'b1) both_seen++;
    if (edit_mode === 1'b1 && !prev_edit) edit_rise_cyc = cyc;
    prev_edit = (edit_mode === 1'b1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Mask bits: 0 inc, 1 dec, 2 confirm, 3 clear. Held long enough to debounce, then released.
  task automatic press(input logic [3:0] m);
    @(negedge clk);
    {btn_clear, btn_confirm, btn_dec, btn_inc} = m;
    repeat (10) @(negedge clk);
    {btn_clear, btn_confirm, btn_dec, btn_inc} = 4'b0000;
    repeat (10) @(negedge clk);
  endtask

  function automatic int model_step(input int p, input logic [3:0] m);
    if (m[3]) return 10;
    if (m[0] && m[1]) return p;
    if (m[0]) return (p + 1 > 15) ? 15 : p + 1;
    if (m[1]) return (p - 1 < 1) ? 1 : p - 1;
    return p;
  endfunction

  typedef struct {
    logic [3:0] btns;
    int         exp_time;
    int         exp_starts;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int p;
    int s0;
    int e0;
    logic [3:0] m;

    // Stimulus table: 6 inc, 20 dec, then coincident-press corner cases.
    for (int i = 0; i < 6; i++) vecs.push_back('{4'b0001, (11 + i > 15) ? 15 : 11 + i, 0});
    for (int i = 0; i < 20; i++) vecs.push_back('{4'b0010, (14 - i < 1) ? 1 : 14 - i, 0});
    vecs.push_back('{4'b0011, 1, 0});
    vecs.push_back('{4'b1000, 10, 0});
    vecs.push_back('{4'b0001, 11, 0});
    vecs.push_back('{4'b1100, 10, 0});
    vecs.push_back('{4'b0011, 10, 0});

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_time", int'(countdown_time), 10);
    check("reset_edit", int'(edit_mode), 1);
    check("reset_start", int'(ifc.start), 0);
    check("reset_end", int'(ifc.end_timer), 0);
    check("reset_finished", int'(finished), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Three-cycle glitch must be rejected.
    btn_inc = 1'b1;
    repeat (3) @(negedge clk);
    btn_inc = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_time", int'(countdown_time), 10);

    foreach (vecs[i]) begin
      s0 = start_total;
      press(vecs[i].btns);
      check($sformatf("vec%0d_time", i), int'(countdown_time), vecs[i].exp_time);
      check($sformatf("vec%0d_edit", i), int'(edit_mode), 1);
      check($sformatf("vec%0d_starts", i), start_total - s0, vecs[i].exp_starts);
    end

    // Random edits against the arithmetic preset model.
    p = 10;
    for (int i = 0; i < 30; i++) begin
      m = 4'($urandom_range(1, 15)) & 4'b1011;
      if (m == 4'b0000) m = 4'b0001;
      p = model_step(p, m);
      press(m);
      check($sformatf("rand%0d_time", i), int'(countdown_time), p);
    end

    // Preset 7, start a run acknowledged by the controller.
    press(4'b1000);
    for (int i = 0; i < 3; i++) press(4'b0010);
    check("preset7", int'(countdown_time), 7);
    ack_en = 1'b1;
    s0 = start_total;
    press(4'b0100);
    check("run1_starts", start_total - s0, 1);
    check("run1_start_width", start_max, 1);
    check("run1_edit", int'(edit_mode), 0);
    check("run1_counting", int'(ifc.counting), 1);
    check("run1_time", int'(countdown_time), 7);

    // Abort from RUN, then controller drops counting without done.
    e0 = end_total;
    press(4'b0100);
    check("abort_end_pulses", end_total - e0, 1);
    check("abort_end_width", end_max, 1);
    check("abort_still_run", int'(edit_mode), 0);
    press(4'b0011);
    check("run_ignores_incdec", int'(countdown_time), 7);
    drop_done = 1'b0;
    drop_cnt++;
    repeat (5) @(negedge clk);
    check("abort_edit", int'(edit_mode), 1);
    check("abort_finished", int'(finished), 0);

    // Natural completion, then clear acknowledges.
    press(4'b0100);
    check("run2_edit", int'(edit_mode), 0);
    drop_done = 1'b1;
    drop_cnt++;
    repeat (5) @(negedge clk);
    check("done_finished", int'(finished), 1);
    check("done_edit", int'(edit_mode), 0);
    press(4'b1000);
    check("ack_finished", int'(finished), 0);
    check("ack_edit", int'(edit_mode), 1);
    check("ack_time", int'(countdown_time), 7);

    // No acknowledge: back to EDIT 16 cycles after start.
    ack_en = 1'b0;
    s0 = start_total;
    press(4'b0100);
    repeat (10) @(negedge clk);
    check("timeout_starts", start_total - s0, 1);
    check("timeout_edit", int'(edit_mode), 1);
    check("timeout_latency", edit_rise_cyc - start_cyc, 16);
    check("timeout_time", int'(countdown_time), 7);

    check("start_end_overlap", both_seen, 0);
    check("start_max_width", start_max, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
